jtframe_pll_rstseq: RTL

JTFRAME_PLL_RSTSEQ -- requirements
Module: jtframe_pll_rstseq

---
 rtl/jtframe_pll_rstseq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/jtframe_pll_rstseq.sv
// PLL bring-up and reset sequencer: PLL reset pulse, lock qualification, staged SDRAM/core release.
// Optional lock-loss counter port loss_cnt is built only with `define JTFRAME_PLL_LOSSCNT_EN.
module jtframe_pll_rstseq #(
    parameter int LOCK_CYC    = 1024,
    parameter int TIMEOUT_CYC = 65536,
    parameter int PLLRST_CYC  = 16,
    parameter int STAGE_GAP   = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       sdram_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [2:0] st
`ifdef JTFRAME_PLL_LOSSCNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);
    localparam int MAX_A = (LOCK_CYC > TIMEOUT_CYC) ? LOCK_CYC : TIMEOUT_CYC;
    localparam int MAX_B = (PLLRST_CYC > STAGE_GAP) ? PLLRST_CYC : STAGE_GAP;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLLRST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_SDRAM_UP  = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lk_meta_q, lk_q;
    logic          pll_rst_q, sdram_rst_q, core_rst_q, ready_q;
    logic          pll_rst_d, sdram_rst_d, core_rst_d, ready_d;

    // locked comes from the PLL domain; only lk_q is used past this point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= locked;
            lk_q      <= lk_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == PLLRST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (!lk_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_SDRAM_UP;
                    cnt_d   = '0;
                end
            end
            S_SDRAM_UP: begin
                if (!lk_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // lock loss is checked first so it wins over a coincident soft reset
                cnt_d = '0;
                if (!lk_q) state_d = S_WAIT_LOCK;
                else if (soft_rst) state_d = S_SDRAM_UP;
            end
            default: begin
                state_d = S_PLLRST;
                cnt_d   = '0;
            end
        endcase

        // outputs decoded from the next state so they are registered alongside it
        pll_rst_d   = (state_d == S_PLLRST);
        sdram_rst_d = (state_d == S_PLLRST) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
        core_rst_d  = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sdram_rst_q <= 1'b1;
            core_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            sdram_rst_q <= sdram_rst_d;
            core_rst_q  <= core_rst_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sdram_rst = sdram_rst_q;
    assign core_rst  = core_rst_q;
    assign ready     = ready_q;
    assign st        = state_q;

`ifdef JTFRAME_PLL_LOSSCNT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    assign loss_evt = !lk_q && (state_q == S_SDRAM_UP || state_q == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loss_q <= '0;
        else if (loss_evt && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
    end

    assign loss_cnt = loss_q;
`endif

endmodule
